// File: rtl/hippo_pkg.sv
// Shared definitions for the hippocampal replay path.
// Holds the default network geometry, the replay scheduler state encoding and
// the per-frame activity vector type (one bit per neuron, input layer in LSBs).
package hippo_pkg;

  localparam int unsigned HippoNeuronsL1  = 6;
  localparam int unsigned HippoNeuronsL2  = 8;
  localparam int unsigned HippoNeuronsL3  = 2;
  localparam int unsigned HippoNumNeurons = HippoNeuronsL1 + HippoNeuronsL2 + HippoNeuronsL3;
  localparam int unsigned HippoBufferSize = 16;
  localparam int unsigned HippoNHist      = 10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSkipChk,
    StDrive,
    StGap,
    StDone
  } replay_state_t;

  typedef logic [HippoNumNeurons-1:0] frame_vec_t;

endpackage

// File: rtl/replay_frame_mux.sv
// Combinational frame selector for replay.
// Picks history frame frame_sel out of the three snapshot buses, concatenates it
// as {out, hippo, in} and expands every active neuron bit into an I_REPLAY word.
//   in_snap / hippo_snap / out_snap : packed histories, frame k at [(k+1)*W-1 -: W]
//   frame_sel                       : frame index to select
//   frame_vec                       : selected activity bits (input layer in LSBs)
//   words                           : per-neuron current, neuron n at [(n+1)*BUFFER_SIZE-1 -: BUFFER_SIZE]
module replay_frame_mux
  import hippo_pkg::*;
#(
  parameter int unsigned NEURONS_L1  = HippoNeuronsL1,
  parameter int unsigned NEURONS_L2  = HippoNeuronsL2,
  parameter int unsigned NEURONS_L3  = HippoNeuronsL3,
  parameter int unsigned NUM_NEURONS = NEURONS_L1 + NEURONS_L2 + NEURONS_L3,
  parameter int unsigned BUFFER_SIZE = HippoBufferSize,
  parameter int unsigned N_HIST      = HippoNHist,
  parameter logic [BUFFER_SIZE-1:0] I_REPLAY = 16'h0800
) (
  input  logic [N_HIST*NEURONS_L1-1:0]         in_snap,
  input  logic [N_HIST*NEURONS_L2-1:0]         hippo_snap,
  input  logic [N_HIST*NEURONS_L3-1:0]         out_snap,
  input  logic [$clog2(N_HIST)-1:0]            frame_sel,
  output logic [NUM_NEURONS-1:0]               frame_vec,
  output logic [NUM_NEURONS*BUFFER_SIZE-1:0]   words
);

  localparam int unsigned FW = $clog2(N_HIST);

  always_comb begin
    frame_vec = '0;
    for (int f = 0; f < N_HIST; f++) begin
      if (frame_sel == FW'(f)) begin
        frame_vec = {out_snap[f*NEURONS_L3 +: NEURONS_L3],
                     hippo_snap[f*NEURONS_L2 +: NEURONS_L2],
                     in_snap[f*NEURONS_L1 +: NEURONS_L1]};
      end
    end
  end

  always_comb begin
    words = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      words[n*BUFFER_SIZE +: BUFFER_SIZE] = frame_vec[n] ? I_REPLAY : '0;
    end
  end

endmodule

// File: rtl/hippo_replay_scheduler.sv
// Replay-phase sequencer for the three-layer hippocampal network.
// On a rising edge of break_i the spike histories and the reward flag are
// snapshotted; a rewarded trial replays the frames oldest-first as current
// injection, each non-empty frame followed by a membrane-rest gap, N_REPEAT times.
//   clk, reset (sync, active-low)
//   break_i, rewarded, in_hst, hippo_hst, out_hst : trial controller / history inputs
//   iin_replay          : per-neuron replay current
//   learning_rest       : rest gap indicator
//   start_replay_phase  : STDP replay enable
//   finish_replay_phase : one-cycle completion pulse
//   busy, frame_idx     : status
module hippo_replay_scheduler
  import hippo_pkg::*;
#(
  parameter int unsigned NEURONS_L1  = HippoNeuronsL1,
  parameter int unsigned NEURONS_L2  = HippoNeuronsL2,
  parameter int unsigned NEURONS_L3  = HippoNeuronsL3,
  parameter int unsigned NUM_NEURONS = NEURONS_L1 + NEURONS_L2 + NEURONS_L3,
  parameter int unsigned BUFFER_SIZE = HippoBufferSize,
  parameter int unsigned N_HIST      = HippoNHist,
  parameter logic [BUFFER_SIZE-1:0] I_REPLAY = 16'h0800,
  parameter int unsigned DWELL       = 10,
  parameter int unsigned REST        = 5,
  parameter int unsigned N_REPEAT    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               break_i,
  input  logic                               rewarded,
  input  logic [N_HIST*NEURONS_L1-1:0]       in_hst,
  input  logic [N_HIST*NEURONS_L2-1:0]       hippo_hst,
  input  logic [N_HIST*NEURONS_L3-1:0]       out_hst,
  output logic [NUM_NEURONS*BUFFER_SIZE-1:0] iin_replay,
  output logic                               learning_rest,
  output logic                               start_replay_phase,
  output logic                               finish_replay_phase,
  output logic                               busy,
  output logic [$clog2(N_HIST)-1:0]          frame_idx
);

  localparam int unsigned FW     = $clog2(N_HIST);
  localparam int unsigned MaxCyc = (DWELL > REST) ? DWELL : REST;
  localparam int unsigned CW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned PW     = $clog2(N_REPEAT + 1);
  localparam int unsigned WW     = NUM_NEURONS * BUFFER_SIZE;

  replay_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] pass_q, pass_d, pass_inc;
  logic          break_q, rew_q, rew_d;
  logic          trig, snap_load, advance, qual;
  logic          rest_q, rest_d;
  logic [WW-1:0] iin_q, iin_d;

  logic [N_HIST*NEURONS_L1-1:0] in_snap_q;
  logic [N_HIST*NEURONS_L2-1:0] hippo_snap_q;
  logic [N_HIST*NEURONS_L3-1:0] out_snap_q;

  logic [NUM_NEURONS-1:0] frame_vec;
  logic [WW-1:0]          frame_words;

  replay_frame_mux #(
    .NEURONS_L1  (NEURONS_L1),
    .NEURONS_L2  (NEURONS_L2),
    .NEURONS_L3  (NEURONS_L3),
    .NUM_NEURONS (NUM_NEURONS),
    .BUFFER_SIZE (BUFFER_SIZE),
    .N_HIST      (N_HIST),
    .I_REPLAY    (I_REPLAY)
  ) u_frame_mux (
    .in_snap    (in_snap_q),
    .hippo_snap (hippo_snap_q),
    .out_snap   (out_snap_q),
    .frame_sel  (frame_q),
    .frame_vec  (frame_vec),
    .words      (frame_words)
  );

  assign trig     = break_i & ~break_q;
  assign pass_inc = pass_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    pass_d    = pass_q;
    rew_d     = rew_q;
    snap_load = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (trig) begin
          snap_load = 1'b1;
          rew_d     = rewarded;
          frame_d   = FW'(N_HIST - 1);
          pass_d    = '0;
          state_d   = rewarded ? StStart : StDone;
        end
      end
      StStart: state_d = rew_q ? StSkipChk : StDone;
      StSkipChk: begin
        if (frame_vec == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d   = CW'(DWELL - 1);
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(REST - 1);
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Oldest-to-newest walk; a completed pass reloads the oldest frame.
    if (advance) begin
      if (frame_q != '0) begin
        frame_d = frame_q - FW'(1);
        state_d = StSkipChk;
      end else begin
        pass_d  = pass_inc;
        frame_d = FW'(N_HIST - 1);
        state_d = (pass_inc == PW'(N_REPEAT)) ? StDone : StSkipChk;
      end
    end

    // Trial resumed mid-replay: abandon without a finish pulse.
    if (!break_i && (state_q != StIdle) && (state_q != StDone)) begin
      state_d = StIdle;
    end

    // Registered outputs follow the state being entered so they line up with it.
    iin_d  = (state_d == StDrive) ? frame_words : '0;
    rest_d = (state_d == StGap);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      frame_q      <= '0;
      pass_q       <= '0;
      break_q      <= 1'b0;
      rew_q        <= 1'b0;
      rest_q       <= 1'b0;
      iin_q        <= '0;
      in_snap_q    <= '0;
      hippo_snap_q <= '0;
      out_snap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      pass_q  <= pass_d;
      break_q <= break_i;
      rew_q   <= rew_d;
      rest_q  <= rest_d;
      iin_q   <= iin_d;
      if (snap_load) begin
        in_snap_q    <= in_hst;
        hippo_snap_q <= hippo_hst;
        out_snap_q   <= out_hst;
      end
    end
  end

  // Outputs drop in the same cycle break_i falls; DONE still finishes cleanly.
  assign qual                = break_i | (state_q == StDone);
  assign busy                = qual & (state_q != StIdle);
  assign start_replay_phase  = qual & ((state_q == StStart) | (state_q == StSkipChk) |
                                       (state_q == StDrive) | (state_q == StGap));
  assign finish_replay_phase = (state_q == StDone);
  assign learning_rest       = qual & rest_q;
  assign iin_replay          = qual ? iin_q : '0;
  assign frame_idx           = busy ? frame_q : '0;

endmodule

// File: tb/tb_hippo_replay_scheduler.sv
module tb_hippo_replay_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: N_HIST=2, DWELL=3, REST=2, N_REPEAT=1
  logic         brk_a, rew_a;
  logic [11:0]  in_a;
  logic [15:0]  hip_a;
  logic [3:0]   out_a;
  logic [255:0] iin_a;
  logic         rest_a, start_a, fin_a, busy_a;
  logic [0:0]   fidx_a;

  // Instance B: default parameters
  logic         brk_b, rew_b;
  logic [59:0]  in_b;
  logic [79:0]  hip_b;
  logic [19:0]  out_b;
  logic [255:0] iin_b;
  logic         rest_b, start_b, fin_b, busy_b;
  logic [3:0]   fidx_b;

  hippo_replay_scheduler #(
    .N_HIST   (2),
    .DWELL    (3),
    .REST     (2),
    .N_REPEAT (1)
  ) dut_a (
    .clk                 (clk),
    .reset               (reset),
    .break_i             (brk_a),
    .rewarded            (rew_a),
    .in_hst              (in_a),
    .hippo_hst           (hip_a),
    .out_hst             (out_a),
    .iin_replay          (iin_a),
    .learning_rest       (rest_a),
    .start_replay_phase  (start_a),
    .finish_replay_phase (fin_a),
    .busy                (busy_a),
    .frame_idx           (fidx_a)
  );

  hippo_replay_scheduler dut_b (
    .clk                 (clk),
    .reset               (reset),
    .break_i             (brk_b),
    .rewarded            (rew_b),
    .in_hst              (in_b),
    .hippo_hst           (hip_b),
    .out_hst             (out_b),
    .iin_replay          (iin_b),
    .learning_rest       (rest_b),
    .start_replay_phase  (start_b),
    .finish_replay_phase (fin_b),
    .busy                (busy_b),
    .frame_idx           (fidx_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every set mask bit n becomes a 16'h0800 word at neuron n.
  function automatic logic [255:0] expand(input logic [15:0] m);
    logic [255:0] w;
    w = '0;
    for (int n = 0; n < 16; n++) w[n*16 +: 16] = m[n] ? 16'h0800 : 16'h0000;
    return w;
  endfunction

  typedef struct {
    logic        brk;
    logic        rew;
    logic [11:0] in_hst;
    logic [15:0] mask;   // expected active neurons in iin_replay
    logic [4:0]  ctl;    // expected {learning_rest, start, finish, busy, frame_idx}
  } vec_t;

  function automatic vec_t mk(input logic brk, input logic rew, input logic [11:0] in_hst,
                              input logic [15:0] mask, input logic [4:0] ctl);
    vec_t v;
    v.brk = brk; v.rew = rew; v.in_hst = in_hst; v.mask = mask; v.ctl = ctl;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int found, s_k, f_k, d_k, drv, rst, bad;
    logic fin_seen;

    // Snapshot holds 12'h041: neuron 0 active in frame 1 (bits 11:6) and frame 0 (bits 5:0).
    // From vec 2 on the live input flips to 12'hFBE to prove the snapshot is used.
    vecs[0]  = mk(1, 1, 12'h041, 16'h0000, 5'b01011);  // START, frame 1
    vecs[1]  = mk(1, 1, 12'h041, 16'h0000, 5'b01011);  // SKIPCHK
    vecs[2]  = mk(1, 1, 12'hFBE, 16'h0001, 5'b01011);  // DRIVE x3
    vecs[3]  = mk(1, 1, 12'hFBE, 16'h0001, 5'b01011);
    vecs[4]  = mk(1, 1, 12'hFBE, 16'h0001, 5'b01011);
    vecs[5]  = mk(1, 1, 12'hFBE, 16'h0000, 5'b11011);  // GAP x2
    vecs[6]  = mk(1, 1, 12'hFBE, 16'h0000, 5'b11011);
    vecs[7]  = mk(1, 1, 12'hFBE, 16'h0000, 5'b01010);  // SKIPCHK, frame 0
    vecs[8]  = mk(1, 1, 12'hFBE, 16'h0001, 5'b01010);  // DRIVE x3
    vecs[9]  = mk(1, 1, 12'hFBE, 16'h0001, 5'b01010);
    vecs[10] = mk(1, 1, 12'hFBE, 16'h0001, 5'b01010);
    vecs[11] = mk(1, 1, 12'hFBE, 16'h0000, 5'b11010);  // GAP x2
    vecs[12] = mk(1, 1, 12'hFBE, 16'h0000, 5'b11010);
    vecs[13] = mk(1, 1, 12'hFBE, 16'h0000, 5'b00111);  // DONE, 14th cycle from START
    vecs[14] = mk(1, 1, 12'hFBE, 16'h0000, 5'b00000);  // IDLE, break still high
    vecs[15] = mk(1, 1, 12'hFBE, 16'h0000, 5'b00000);

    reset = 1'b0;
    brk_a = 0; rew_a = 0; in_a = '0; hip_a = '0; out_a = '0;
    brk_b = 0; rew_b = 0; in_b = '0; hip_b = '0; out_b = '0;
    repeat (2) @(negedge clk);
    check("reset A iin", iin_a, '0);
    check("reset A ctl", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b0));
    check("reset B ctl", 256'({iin_b != '0, rest_b, start_b, fin_b, busy_b, fidx_b}), 256'(9'b0));
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      brk_a = vecs[i].brk; rew_a = vecs[i].rew; in_a = vecs[i].in_hst;
      @(negedge clk);
      check($sformatf("vec%0d iin", i), iin_a, expand(vecs[i].mask));
      check($sformatf("vec%0d ctl", i), 256'({rest_a, start_a, fin_a, busy_a, fidx_a}),
            256'(vecs[i].ctl));
    end

    // Unrewarded trial: finish one cycle after the edge, no replay.
    brk_a = 0; in_a = 12'h041;
    @(negedge clk);
    brk_a = 1; rew_a = 0;
    @(negedge clk);
    check("unrew done ctl", 256'({rest_a, start_a, fin_a, busy_a}), 256'(4'b0011));
    check("unrew done iin", iin_a, '0);
    @(negedge clk);
    check("unrew idle ctl", 256'({rest_a, start_a, fin_a, busy_a}), 256'(4'b0000));

    // Abort during frame-0 DRIVE, then restart from the oldest frame.
    brk_a = 0;
    @(negedge clk);
    brk_a = 1; rew_a = 1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (iin_a != '0 && fidx_a == 1'b0) found = 1;
    end
    check("abort reach drive f0", 256'(found), 256'(1));
    brk_a = 0;
    #1;
    check("abort same-cycle ctl", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b0));
    check("abort same-cycle iin", iin_a, '0);
    fin_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      fin_seen = fin_seen | fin_a;
    end
    check("abort no finish", 256'(fin_seen), 256'(0));
    brk_a = 1;
    @(negedge clk);
    check("restart START ctl", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b01011));

    // Reset during GAP, held for a second edge where break_i looks like a fresh edge.
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (rest_a) found = 1;
    end
    check("reach gap", 256'(found), 256'(1));
    reset = 1'b0;
    @(negedge clk);
    check("reset mid-gap ctl", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b0));
    check("reset mid-gap iin", iin_a, '0);
    @(negedge clk);
    check("reset beats trig", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b0));
    brk_a = 0; reset = 1'b1;
    @(negedge clk);
    check("post reset idle", 256'({rest_a, start_a, fin_a, busy_a, fidx_a}), 256'(5'b0));

    // Defaults, all-empty histories: START..DONE spans 1+3*10+1 = 32 cycles.
    rew_b = 1; brk_b = 1;
    s_k = -1; f_k = -1; drv = 0; rst = 0;
    for (int k = 1; k <= 200 && f_k < 0; k++) begin
      @(negedge clk);
      if (start_b && s_k < 0) s_k = k;
      if (fin_b) f_k = k;
      if (iin_b != '0) drv++;
      if (rest_b) rst++;
    end
    check("empty start latency", 256'(s_k), 256'(1));
    check("empty span", 256'(f_k - s_k), 256'(31));
    check("empty no drive", 256'(drv), 256'(0));
    check("empty no rest", 256'(rst), 256'(0));
    brk_b = 0;
    @(negedge clk);

    // Defaults, only the oldest frame active (hippocampal bit 0 -> neuron 6):
    // per pass 1+10+5 + 9 empty = 25 cycles, DONE at 1+75+1.
    hip_b = '0; hip_b[72] = 1'b1;
    brk_b = 1;
    s_k = -1; f_k = -1; d_k = -1; drv = 0; rst = 0; bad = 0;
    for (int k = 1; k <= 300 && f_k < 0; k++) begin
      @(negedge clk);
      if (k == 4) hip_b = {80{1'b1}};
      if (start_b && s_k < 0) s_k = k;
      if (fin_b) f_k = k;
      if (iin_b != '0) begin
        drv++;
        if (d_k < 0) d_k = k;
        if (iin_b != expand(16'h0040)) bad++;
      end
      if (rest_b) rst++;
    end
    check("one-frame first drive", 256'(d_k), 256'(3));
    check("one-frame finish", 256'(f_k), 256'(77));
    check("one-frame drive count", 256'(drv), 256'(30));
    check("one-frame rest count", 256'(rst), 256'(15));
    check("one-frame words", 256'(bad), 256'(0));
    @(negedge clk);
    check("no retrigger B", 256'({start_b, fin_b, busy_b}), 256'(3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
